// File: rtl/wall_collision_scanner_if.sv
// Bus between the wall collision scanner and its surroundings: start/player request,
// the wall position read port, and the scan results.
interface wall_collision_scanner_if #(
  parameter int COORD_W = 11,
  parameter int IDX_W   = 4
);
  logic               start;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic [IDX_W-1:0]   wall_sel;
  logic [COORD_W-1:0] wall_x;
  logic [COORD_W-1:0] wall_y;
  logic               busy;
  logic               done;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W:0]     hit_count;

  // The master requests scans and serves wall positions for wall_sel.
  modport master (
    output start, player_x, player_y, wall_x, wall_y,
    input  wall_sel, busy, done, hit, hit_idx, hit_count
  );

  modport slave (
    input  start, player_x, player_y, wall_x, wall_y,
    output wall_sel, busy, done, hit, hit_idx, hit_count
  );
endinterface

// File: rtl/wall_collision_scanner.sv
// Steps wall_sel through every wall, one per pixel_clk, and tests each wall box
// against the player box latched at start; reports any-hit, first hit index and hit count.
module wall_collision_scanner #(
  parameter int WALL_NUM = 10,
  parameter int IDX_W    = 4,
  parameter int COORD_W  = 11,
  parameter int WALL_W   = 32,
  parameter int WALL_H   = 32,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16
) (
  input logic                   pixel_clk,
  input logic                   reset,
  wall_collision_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int SUM_W = COORD_W + 1;
  localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(WALL_NUM - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     cnt_q, cnt_d;

  // One extra bit on every sum keeps boxes near the right/bottom screen edge from wrapping.
  logic [SUM_W-1:0] wx_e, wy_e, px_e, py_e;
  logic             overlap;

  assign wx_e = {1'b0, bus.wall_x};
  assign wy_e = {1'b0, bus.wall_y};
  assign px_e = {1'b0, px_q};
  assign py_e = {1'b0, py_q};

  assign overlap = (wx_e < px_e + SUM_W'(PLAYER_W)) && (px_e < wx_e + SUM_W'(WALL_W)) &&
                   (wy_e < py_e + SUM_W'(PLAYER_H)) && (py_e < wy_e + SUM_W'(WALL_H));

  // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    px_d    = px_q;
    py_d    = py_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          px_d    = bus.player_x;
          py_d    = bus.player_y;
          hit_d   = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          sel_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (overlap) begin
          cnt_d = cnt_q + 1'b1;
          hit_d = 1'b1;
          if (!hit_q) idx_d = sel_q;
        end
        if (sel_q == LAST_SEL) begin
          sel_d   = '0;
          state_d = DONE;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      DONE: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wall_sel  = sel_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.hit       = hit_q;
  assign bus.hit_idx   = idx_q;
  assign bus.hit_count = cnt_q;

endmodule

// File: tb/tb_wall_collision_scanner.sv
// Scoreboard bench for wall_collision_scanner: a behavioural overlap model queues the
// expected result at each start, and each scenario pops and compares it at done.
module tb_wall_collision_scanner;
  localparam int WALL_NUM = 10;
  localparam int IDX_W    = 4;
  localparam int COORD_W  = 11;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  wall_collision_scanner_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) bus ();

  wall_collision_scanner #(
    .WALL_NUM(WALL_NUM), .IDX_W(IDX_W), .COORD_W(COORD_W),
    .WALL_W(32), .WALL_H(32), .PLAYER_W(16), .PLAYER_H(16)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .bus(bus)
  );

  // Wall array, read combinationally by wall_sel.
  logic [COORD_W-1:0] wx [16];
  logic [COORD_W-1:0] wy [16];
  always_comb begin
    bus.wall_x = wx[bus.wall_sel];
    bus.wall_y = wy[bus.wall_sel];
  end

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cnt;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic res_t model(input int px, input int py);
    res_t r;
    int   x, y;
    r = '0;
    for (int i = 0; i < WALL_NUM; i++) begin
      x = int'(wx[i]);
      y = int'(wy[i]);
      if (x < px + 16 && px < x + 32 && y < py + 16 && py < y + 32) begin
        if (!r.hit) r.idx = IDX_W'(i);
        r.hit = 1'b1;
        r.cnt = r.cnt + 1'b1;
      end
    end
    return r;
  endfunction

  task automatic set_walls(input int x, input int y);
    for (int i = 0; i < 16; i++) begin
      wx[i] = COORD_W'(x);
      wy[i] = COORD_W'(y);
    end
  endtask

  // Drives start ahead of edge E0, queues the expected result, returns just after E0.
  task automatic start_scan(input int px, input int py, input bit hold);
    bus.player_x = COORD_W'(px);
    bus.player_y = COORD_W'(py);
    bus.start    = 1'b1;
    sb.push_back(model(px, py));
    @(posedge pixel_clk); #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Counts edges until done (bounded) and the cycles busy was seen high.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      @(posedge pixel_clk); #1;
      lat++;
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    res_t got;
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.player_x = '0;
    bus.player_y = '0;
    set_walls(600, 400);
    repeat (3) @(posedge pixel_clk);
    #1;
    checks++;
    if ({bus.wall_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.hit_count} !== '0) begin
      failures++;
      $display("FAIL reset_held: sel=%0d busy=%0b done=%0b hit=%0b idx=%0d cnt=%0d, expected all 0",
               bus.wall_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.hit_count);
    end
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    got = {bus.hit, bus.hit_idx, bus.hit_count};
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wall_sel !== '0 || got !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: sel=%0d busy=%0b done=%0b res=%h, expected all 0",
               bus.wall_sel, bus.busy, bus.done, got);
    end
  endtask

  task automatic test_no_overlap();
    int lat, busy_n;
    res_t got, exp;
    set_walls(600, 400);
    start_scan(100, 100, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.wall_sel !== '0) begin
      failures++;
      $display("FAIL no_overlap_after_e0: busy=%0b sel=%0d, expected busy=1 sel=0", bus.busy, bus.wall_sel);
    end
    wait_done(lat, busy_n);
    checks++;
    if (lat !== WALL_NUM) begin
      failures++;
      $display("FAIL no_overlap_latency: got %0d cycles, expected %0d", lat, WALL_NUM);
    end
    checks++;
    if (busy_n !== WALL_NUM) begin
      failures++;
      $display("FAIL no_overlap_busy_cycles: got %0d, expected %0d", busy_n, WALL_NUM);
    end
    got = {bus.hit, bus.hit_idx, bus.hit_count};
    exp = sb.pop_front();
    checks++;
    if (got !== exp || got !== '0) begin
      failures++;
      $display("FAIL no_overlap_result: got hit=%0b idx=%0d cnt=%0d, expected hit=%0b idx=%0d cnt=%0d",
               got.hit, got.idx, got.cnt, exp.hit, exp.idx, exp.cnt);
    end
    @(posedge pixel_clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL no_overlap_done_pulse: done=%0b busy=%0b one cycle later, expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_single_hit();
    int lat, busy_n;
    res_t got, exp;
    set_walls(600, 400);
    wx[3] = 100;
    wy[3] = 100;
    start_scan(110, 110, 1'b0);
    // Moving the player onto every wall mid-scan must not change the result.
    bus.player_x = 600;
    bus.player_y = 400;
    wait_done(lat, busy_n);
    got = {bus.hit, bus.hit_idx, bus.hit_count};
    exp = sb.pop_front();
    checks++;
    if (lat !== WALL_NUM || got !== exp) begin
      failures++;
      $display("FAIL single_hit: lat=%0d hit=%0b idx=%0d cnt=%0d, expected lat=%0d hit=%0b idx=%0d cnt=%0d",
               lat, got.hit, got.idx, got.cnt, WALL_NUM, exp.hit, exp.idx, exp.cnt);
    end
    checks++;
    if (bus.hit_idx !== 4'd3 || bus.hit_count !== 5'd1) begin
      failures++;
      $display("FAIL single_hit_idx: idx=%0d cnt=%0d, expected idx=3 cnt=1", bus.hit_idx, bus.hit_count);
    end
    @(posedge pixel_clk); #1;
  endtask

  task automatic test_edge_touch();
    int lat, busy_n;
    res_t got, exp;
    int cases_x [3] = '{116, 115, 2040};
    int cases_p [3] = '{100, 100, 2030};
    for (int c = 0; c < 3; c++) begin
      set_walls(600, 400);
      if (c < 2) begin
        wx[0] = COORD_W'(cases_x[c]);
        wy[0] = 100;
      end else begin
        wx[9] = COORD_W'(cases_x[c]);
        wy[9] = COORD_W'(cases_x[c]);
      end
      start_scan(cases_p[c], cases_p[c], 1'b0);
      wait_done(lat, busy_n);
      got = {bus.hit, bus.hit_idx, bus.hit_count};
      exp = sb.pop_front();
      checks++;
      if (lat !== WALL_NUM || got !== exp) begin
        failures++;
        $display("FAIL edge_touch_%0d: lat=%0d hit=%0b idx=%0d cnt=%0d, expected lat=%0d hit=%0b idx=%0d cnt=%0d",
                 c, lat, got.hit, got.idx, got.cnt, WALL_NUM, exp.hit, exp.idx, exp.cnt);
      end
      @(posedge pixel_clk); #1;
    end
    checks++;
    if (bus.hit !== 1'b1 || bus.hit_idx !== 4'd9) begin
      failures++;
      $display("FAIL edge_touch_no_wrap: hit=%0b idx=%0d, expected hit=1 idx=9", bus.hit, bus.hit_idx);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    res_t got, exp;
    set_walls(600, 400);
    wx[2] = 100; wy[2] = 100;
    wx[5] = 110; wy[5] = 90;
    wx[9] = 90;  wy[9] = 110;
    start_scan(100, 100, 1'b1);
    wait_done(lat, busy_n);
    got = {bus.hit, bus.hit_idx, bus.hit_count};
    exp = sb.pop_front();
    checks++;
    if (lat !== WALL_NUM || got !== exp) begin
      failures++;
      $display("FAIL multi_hit: lat=%0d hit=%0b idx=%0d cnt=%0d, expected lat=%0d hit=%0b idx=%0d cnt=%0d",
               lat, got.hit, got.idx, got.cnt, WALL_NUM, exp.hit, exp.idx, exp.cnt);
    end
    checks++;
    if (bus.hit_idx !== 4'd2 || bus.hit_count !== 5'd3) begin
      failures++;
      $display("FAIL multi_hit_idx: idx=%0d cnt=%0d, expected idx=2 cnt=3", bus.hit_idx, bus.hit_count);
    end
    // New wall layout for the second scan that starts from the held start.
    set_walls(600, 400);
    wx[7] = 100; wy[7] = 100;
    sb.push_back(model(100, 100));
    @(posedge pixel_clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hit !== 1'b1 || bus.hit_count !== 5'd3) begin
      failures++;
      $display("FAIL multi_hold_idle: done=%0b busy=%0b hit=%0b cnt=%0d, expected 0 0 1 3",
               bus.done, bus.busy, bus.hit, bus.hit_count);
    end
    @(posedge pixel_clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.wall_sel !== '0 || bus.hit !== 1'b0 || bus.hit_idx !== '0 ||
        bus.hit_count !== '0) begin
      failures++;
      $display("FAIL second_scan_clear: busy=%0b sel=%0d hit=%0b idx=%0d cnt=%0d, expected 1 0 0 0 0",
               bus.busy, bus.wall_sel, bus.hit, bus.hit_idx, bus.hit_count);
    end
    wait_done(lat, busy_n);
    got = {bus.hit, bus.hit_idx, bus.hit_count};
    exp = sb.pop_front();
    checks++;
    if (lat !== WALL_NUM || got !== exp) begin
      failures++;
      $display("FAIL second_scan: lat=%0d hit=%0b idx=%0d cnt=%0d, expected lat=%0d hit=%0b idx=%0d cnt=%0d",
               lat, got.hit, got.idx, got.cnt, WALL_NUM, exp.hit, exp.idx, exp.cnt);
    end
    @(posedge pixel_clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int   n, lat, busy_n;
    bit   done_seen;
    res_t got, exp;
    set_walls(600, 400);
    wx[1] = 100; wy[1] = 100;
    start_scan(100, 100, 1'b0);
    n = 0;
    while (bus.wall_sel != 4'd4 && n < 20) begin
      @(posedge pixel_clk); #1;
      n++;
    end
    checks++;
    if (bus.wall_sel !== 4'd4 || bus.hit !== 1'b1) begin
      failures++;
      $display("FAIL mid_reach_sel4: sel=%0d hit=%0b, expected sel=4 hit=1", bus.wall_sel, bus.hit);
    end
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({bus.wall_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.hit_count} !== '0) begin
      failures++;
      $display("FAIL mid_reset_immediate: sel=%0d busy=%0b done=%0b hit=%0b idx=%0d cnt=%0d, expected all 0",
               bus.wall_sel, bus.busy, bus.done, bus.hit, bus.hit_idx, bus.hit_count);
    end
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge pixel_clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge pixel_clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_done: done pulse seen=%0b, expected 0", done_seen);
    end
    start_scan(100, 100, 1'b0);
    checks++;
    if (bus.wall_sel !== 4'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_sel0: sel=%0d busy=%0b, expected sel=0 busy=1", bus.wall_sel, bus.busy);
    end
    @(posedge pixel_clk); #1;
    checks++;
    if (bus.wall_sel !== 4'd1 || bus.hit !== 1'b0) begin
      failures++;
      $display("FAIL restart_sel1: sel=%0d hit=%0b, expected sel=1 hit=0", bus.wall_sel, bus.hit);
    end
    @(posedge pixel_clk); #1;
    checks++;
    if (bus.wall_sel !== 4'd2 || bus.hit !== 1'b1) begin
      failures++;
      $display("FAIL restart_sel2: sel=%0d hit=%0b, expected sel=2 hit=1", bus.wall_sel, bus.hit);
    end
    wait_done(lat, busy_n);
    got = {bus.hit, bus.hit_idx, bus.hit_count};
    exp = sb.pop_front();
    checks++;
    if (lat !== WALL_NUM - 2 || got !== exp) begin
      failures++;
      $display("FAIL restart_result: lat=%0d hit=%0b idx=%0d cnt=%0d, expected lat=%0d hit=%0b idx=%0d cnt=%0d",
               lat, got.hit, got.idx, got.cnt, WALL_NUM - 2, exp.hit, exp.idx, exp.cnt);
    end
    @(posedge pixel_clk); #1;
  endtask

  initial begin
    test_reset();
    test_no_overlap();
    test_single_hit();
    test_edge_touch();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
